ps2_scancode_rx: RTL and testbench

- Receives PS/2 keyboard device-to-host frames on the PS2_CLK/PS2_DATA lines.
- Presents each accepted byte as an 8-bit SCANCODE with a one-cycle VALID strobe.
- Sits between the keyboard pins and the seven-segment scancode display and VGA logic, which consume SCANCODE directly.
- Receive-only block. It never drives the PS/2 lines.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_scancode_rx_if.sv | 39 +++
 rtl/ps2_sync_filter.sv | 49 ++++
 rtl/ps2_scancode_rx.sv | 158 +++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
//   ps2_state_e   : frame receiver state (IDLE, DATA, PARITY, STOP)
//   PS2_BREAK_CODE: keyboard break prefix byte
//   PS2_FRAME_BITS: bits per device-to-host frame (start, 8 data, parity, stop)
//   odd_parity_ok : true when data bits plus parity bit hold an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 11;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Pin-side and result-side signals of the PS/2 scancode receiver.
//   PS2_CLK, PS2_DATA : raw keyboard lines (idle high)
//   SCANCODE          : last accepted byte
//   VALID             : one-cycle strobe when SCANCODE updates
//   PARITY_ERR        : one-cycle strobe on odd-parity failure
//   FRAME_ERR         : one-cycle strobe on bad start/stop or timeout
//   RELEASE           : break flag qualifying SCANCODE
// master: the receiver; slave: the keyboard/consumer side.
interface ps2_scancode_rx_if;

  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] SCANCODE;
  logic       VALID;
  logic       PARITY_ERR;
  logic       FRAME_ERR;
  logic       RELEASE;

  modport master (
    input  PS2_CLK,
    input  PS2_DATA,
    output SCANCODE,
    output VALID,
    output PARITY_ERR,
    output FRAME_ERR,
    output RELEASE
  );

  modport slave (
    output PS2_CLK,
    output PS2_DATA,
    input  SCANCODE,
    input  VALID,
    input  PARITY_ERR,
    input  FRAME_ERR,
    input  RELEASE
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// Two-stage synchronizer plus glitch filter for the PS/2 clock line.
//   clk, rst : system clock, asynchronous active-high reset
//   raw      : asynchronous input line (idles high)
//   fe       : one-cycle pulse on an accepted (filtered) 1->0 transition
// The filtered level only changes after FILTER_LEN consecutive synchronized
// samples that disagree with it.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic fe
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;
  logic          s;

  assign s = sync_q[1];

  // Synchronize, then count consecutive samples that differ from the filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fe     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      fe     <= 1'b0;
      if (s == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= s;
        cnt_q  <= '0;
        fe     <= ~s;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard device-to-host frame receiver.
//   CLK, RST : system clock, asynchronous active-high reset
//   bus      : ps2_scancode_rx_if.master (raw PS/2 lines in; SCANCODE, VALID,
//              PARITY_ERR, FRAME_ERR, RELEASE out, all registered)
// Optional feature macro PS2_BREAK_DECODE_EN: absorbs the 8'hF0 break prefix
// and flags the following byte with RELEASE. Without it, 8'hF0 is an ordinary
// byte and RELEASE is held low.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 17
) (
  input  logic                CLK,
  input  logic                RST,
  ps2_scancode_rx_if.master   bus
);

  ps2_state_e       state_q;
  logic [2:0]       bit_cnt_q;
  logic [CNT_W-1:0] tcnt_q;
  logic [7:0]       shreg_q;
  logic             par_q;
  logic [7:0]       scancode_q;
  logic             valid_q;
  logic             perr_q;
  logic             ferr_q;
  logic [1:0]       data_sync_q;
  logic             fe;
  logic             din;
  logic             timeout;

  // Clock line: synchronized, filtered, reduced to a falling-edge strobe.
  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk(CLK),
    .rst(RST),
    .raw(bus.PS2_CLK),
    .fe (fe)
  );

  // Data line: synchronizer only; it is stable around clock falling edges.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) data_sync_q <= 2'b11;
    else     data_sync_q <= {data_sync_q[0], bus.PS2_DATA};
  end

  assign din     = data_sync_q[1];
  // An edge in the same cycle beats the timeout.
  assign timeout = (state_q != IDLE) && !fe && (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_BREAK_DECODE_EN
  logic pending_q;
  logic release_q;
  assign bus.RELEASE = release_q;
`else
  assign bus.RELEASE = 1'b0;
`endif

  // Frame state machine, timeout counter and registered result strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tcnt_q     <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      scancode_q <= 8'h00;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      pending_q  <= 1'b0;
      release_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;

      if (state_q == IDLE || fe) tcnt_q <= '0;
      else                       tcnt_q <= tcnt_q + CNT_W'(1);

      unique case (state_q)
        IDLE: begin
          // A high data bit on an edge is a stray edge, not a start bit.
          if (fe && !din) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (fe) begin
            shreg_q[bit_cnt_q] <= din;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
        end
        PARITY: begin
          if (fe) begin
            par_q   <= din;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (fe) begin
            state_q <= IDLE;
            if (!din) begin
              ferr_q <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
              pending_q <= 1'b0;
`endif
            end else if (!odd_parity_ok(shreg_q, par_q)) begin
              perr_q <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
              pending_q <= 1'b0;
`endif
            end else begin
`ifdef PS2_BREAK_DECODE_EN
              if (shreg_q == PS2_BREAK_CODE) begin
                pending_q <= 1'b1;
              end else begin
                scancode_q <= shreg_q;
                valid_q    <= 1'b1;
                release_q  <= pending_q;
                pending_q  <= 1'b0;
              end
`else
              scancode_q <= shreg_q;
              valid_q    <= 1'b1;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // Stalled frame: drop partial data and report it.
      if (timeout) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        tcnt_q    <= '0;
        ferr_q    <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
        pending_q <= 1'b0;
`endif
      end
    end
  end

  assign bus.SCANCODE   = scancode_q;
  assign bus.VALID      = valid_q;
  assign bus.PARITY_ERR = perr_q;
  assign bus.FRAME_ERR  = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: stimulus pushes expected strobes,
// a negedge monitor pops and compares whenever a strobe appears.
module tb_ps2_scancode_rx;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT    = 2000;
  localparam int unsigned CNT_W      = 11;
  localparam int          HALF       = 40;

  localparam int K_VALID = 0;
  localparam int K_PERR  = 1;
  localparam int K_FERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       rel;
  } exp_t;

  logic clk;
  logic rst;
  ps2_scancode_rx_if bus ();

  ps2_scancode_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (CNT_W)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic pulse_prev = 1'b0;
  logic [7:0] last_code;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip_par);
    return {1'b1, (~^d) ^ flip_par, d, 1'b0};
  endfunction

  // Bits go out LSB first: start, d0..d7, parity, stop.
  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.PS2_DATA = f[i];
      wait_cyc(HALF / 2);
      bus.PS2_CLK = 1'b0;
      wait_cyc(HALF);
      bus.PS2_CLK = 1'b1;
      wait_cyc(HALF / 2);
    end
    bus.PS2_DATA = 1'b1;
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] code, input logic rel);
    exp_t e;
    e.kind = kind;
    e.code = code;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    int   n;
    int   kind;
    exp_t e;
    logic pulse_now;
    if (!rst) begin
      n = int'(bus.VALID) + int'(bus.PARITY_ERR) + int'(bus.FRAME_ERR);
      pulse_now = (n != 0);
      if (n > 1) begin
        checks++;
        errors++;
        $display("FAIL multi_pulse: valid=%b perr=%b ferr=%b expected one at most",
                 bus.VALID, bus.PARITY_ERR, bus.FRAME_ERR);
      end else if (n == 1) begin
        checks++;
        kind = bus.VALID ? K_VALID : (bus.PARITY_ERR ? K_PERR : K_FERR);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
          e = exp_q.pop_front();
          if (kind != e.kind ||
              (kind == K_VALID && (bus.SCANCODE !== e.code || bus.RELEASE !== e.rel))) begin
            errors++;
            $display("FAIL event: got kind %0d code %h rel %b expected kind %0d code %h rel %b",
                     kind, bus.SCANCODE, bus.RELEASE, e.kind, e.code, e.rel);
          end
        end
      end
      if (pulse_now) begin
        checks++;
        if (pulse_prev) begin
          errors++;
          $display("FAIL pulse_width: got strobe for 2+ cycles expected 1");
        end
      end
      pulse_prev = pulse_now;
    end else begin
      pulse_prev = 1'b0;
    end
  end

  initial begin
    wait_cyc(60000);
    $display("FAIL watchdog: got no finish expected finish before 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.PS2_CLK  = 1'b1;
    bus.PS2_DATA = 1'b1;
    wait_cyc(4);
    check8("reset_scancode", bus.SCANCODE, 8'h00);
    check8("reset_flags", {5'd0, bus.VALID, bus.PARITY_ERR, bus.FRAME_ERR}, 8'h00);
    check8("reset_release", {7'd0, bus.RELEASE}, 8'h00);
    rst = 1'b0;
    wait_cyc(20);
    last_code = 8'h00;

    // Parity error first so SCANCODE must still hold its reset value.
    expect_ev(K_PERR, 8'h00, 1'b0);
    send_bits(mk_frame(8'h1C, 1'b1), 11);
    wait_cyc(20);
    check8("perr_hold_scancode", bus.SCANCODE, 8'h00);

    // Good frame.
    expect_ev(K_VALID, 8'h1C, 1'b0);
    send_bits(mk_frame(8'h1C, 1'b0), 11);
    wait_cyc(20);
    check8("good_1c", bus.SCANCODE, 8'h1C);

    // Bad stop bit.
    expect_ev(K_FERR, 8'h00, 1'b0);
    send_bits(mk_frame(8'h33, 1'b0) & 11'h3FF, 11);
    wait_cyc(20);
    check8("stop_err_hold", bus.SCANCODE, 8'h1C);

    // Timeout after start + 4 data bits, then a full 0x29 frame.
    expect_ev(K_FERR, 8'h00, 1'b0);
    send_bits(mk_frame(8'h29, 1'b0), 5);
    wait_cyc(TIMEOUT + 10);
    check8("timeout_hold", bus.SCANCODE, 8'h1C);
    expect_ev(K_VALID, 8'h29, 1'b0);
    send_bits(mk_frame(8'h29, 1'b0), 11);
    wait_cyc(20);
    check8("after_timeout_29", bus.SCANCODE, 8'h29);

    // Glitches on the clock line in IDLE, then a good frame.
    bus.PS2_CLK = 1'b0;
    wait_cyc(1);
    bus.PS2_CLK = 1'b1;
    wait_cyc(20);
    bus.PS2_CLK = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    bus.PS2_CLK = 1'b1;
    wait_cyc(20);
    check8("glitch_hold", bus.SCANCODE, 8'h29);
    expect_ev(K_VALID, 8'h1C, 1'b0);
    send_bits(mk_frame(8'h1C, 1'b0), 11);
    wait_cyc(20);

    // Back-to-back frames with no gap: 0x12 then 0x34.
    expect_ev(K_VALID, 8'h12, 1'b0);
    expect_ev(K_VALID, 8'h34, 1'b0);
    send_bits(mk_frame(8'h12, 1'b0), 11);
    send_bits(mk_frame(8'h34, 1'b0), 11);
    wait_cyc(20);

    // Break prefix followed by 0x1C.
`ifdef PS2_BREAK_DECODE_EN
    expect_ev(K_VALID, 8'h1C, 1'b1);
`else
    expect_ev(K_VALID, 8'hF0, 1'b0);
    expect_ev(K_VALID, 8'h1C, 1'b0);
`endif
    send_bits(mk_frame(8'hF0, 1'b0), 11);
    send_bits(mk_frame(8'h1C, 1'b0), 11);
    wait_cyc(20);
    check8("break_final", bus.SCANCODE, 8'h1C);

    // Reset after the 5th data bit of 0x5A, then a full 0x5A frame.
    send_bits(mk_frame(8'h5A, 1'b0), 6);
    rst = 1'b1;
    wait_cyc(3);
    check8("midreset_scancode", bus.SCANCODE, 8'h00);
    check8("midreset_flags", {4'd0, bus.RELEASE, bus.VALID, bus.PARITY_ERR, bus.FRAME_ERR}, 8'h00);
    rst = 1'b0;
    wait_cyc(20);
    expect_ev(K_VALID, 8'h5A, 1'b0);
    send_bits(mk_frame(8'h5A, 1'b0), 11);
    wait_cyc(20);
    check8("midreset_final", bus.SCANCODE, 8'h5A);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_cyc(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d outstanding expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
